inst_fetch: RTL



---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/fetch_pc_gen.sv | 39 +++
 rtl/inst_fetch.sv | 117 +++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: constants and types shared by the instruction fetch stage.
// Holds the default reset PC, the NOP encoding, the fetch FSM state encoding
// and the PC increment.
package inst_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'd4;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    // A fetch target is usable only if it is word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection for the fetch stage (reset / redirect /
// +4 / hold) and the alignment check on redirect targets.
// INST_FETCH_ALIGN_CHECK_EN: when defined, a misaligned redirect leaves the
// PC untouched (the FSM enters FAULT); otherwise the target is forced to a
// word boundary.
module fetch_pc_gen
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        adv_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_d_o,
    output logic        misaligned_o
);

    assign misaligned_o = redirect_valid_i && is_misaligned(redirect_pc_i);

    // Priority mux: reset, then redirect, then sequential advance, else hold.
    always_comb begin
        pc_d_o = pc_i;
        if (rst_i) begin
            pc_d_o = RESET_PC;
        end else if (redirect_valid_i) begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
            // Keep the last aligned PC so inst_mem never sees a bad address.
            pc_d_o = misaligned_o ? pc_i : redirect_pc_i;
`else
            pc_d_o = {redirect_pc_i[31:2], 2'b00};
`endif
        end else if (adv_i) begin
            pc_d_o = pc_i + PC_INC;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage. Owns the PC, drives inst_mem and
// holds the IF/ID register presented to decode under valid/ready.
// INST_FETCH_ALIGN_CHECK_EN: when defined, misaligned redirects halt fetch
// in FAULT and report the target on fetch_fault/fault_pc; when undefined,
// those outputs are tied low and misaligned targets are word-aligned.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    fetch_state_e state_q;
    logic [31:0]  pc_q, pc_d;
    logic         id_valid_q;
    logic [31:0]  id_inst_q, id_pc_q, id_pc4_q;
    logic         adv;
    logic         misaligned;

    // id_ready only gates register enables; imem_addr comes straight from pc_q.
    assign adv = (state_q == ST_RUN) && (!id_valid_q || id_ready);

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .rst_i           (rst),
        .pc_i            (pc_q),
        .adv_i           (adv),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .pc_d_o          (pc_d),
        .misaligned_o    (misaligned)
    );

    // Program counter register; next value already prioritised by fetch_pc_gen.
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        fault_q;
    logic [31:0] fault_pc_q;
`else
    logic unused_misaligned;
    assign unused_misaligned = misaligned;
`endif

    // Fetch FSM and IF/ID register: redirect squashes, otherwise capture on adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            id_valid_q <= 1'b0;
            id_inst_q  <= NOP_INST;
            id_pc_q    <= 32'd0;
            id_pc4_q   <= 32'd0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
`endif
        end else if (redirect_valid) begin
            id_valid_q <= 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
                state_q    <= ST_FAULT;
                fault_q    <= 1'b1;
                fault_pc_q <= redirect_pc;
            end else begin
                state_q    <= ST_RUN;
                fault_q    <= 1'b0;
                fault_pc_q <= 32'd0;
            end
`else
            state_q    <= ST_RUN;
`endif
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (adv) begin
                        id_valid_q <= 1'b1;
                        id_inst_q  <= imem_inst;
                        id_pc_q    <= pc_q;
                        id_pc4_q   <= pc_q + PC_INC;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = id_valid_q;
    assign id_inst   = id_inst_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
`else
    assign fetch_fault = 1'b0;
    assign fault_pc    = 32'd0;
`endif

endmodule
